// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver.
//   rx_state_e - receiver frame-tracking states
//   DATA_BITS  - payload bits per frame
//   baud_div() - clock cycles per line bit (integer truncation)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  localparam int unsigned DATA_BITS = 8;

  function automatic int unsigned baud_div(input int unsigned freq_hz,
                                           input int unsigned bauds);
    return freq_hz / bauds;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read.
//   clk, rst_n      - clock, asynchronous active-low reset
//   push_i, data_i  - write request and data; ignored while full unless a pop
//                     happens in the same cycle
//   full_o          - occupancy equals DEPTH
//   pop_i           - read request; ignored while empty
//   data_o, empty_o - head entry (don't-care while empty), no entries held
// DEPTH must be a power of two (at least 2) so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still accepts a write when the head leaves in the same cycle:
  // the slot being written is the one just consumed.
  assign do_push = push_i && (!full_o || do_pop);

  // NOTE: storage has no reset; only pointers and count define what is valid,
  // which keeps the array as plain flops/RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1) with a receive FIFO.
//   clk             - single clock
//   reset_n_i       - asynchronous active-low reset
//   rx_i            - serial line, idle high, asynchronous to clk
//   data_o          - byte at the FIFO head (don't-care while valid_o is 0)
//   valid_o         - FIFO not empty
//   ready_i         - consumer takes data_o when valid_o is also 1
//   framing_error_o - one-cycle pulse when a stop bit samples 0
//   overrun_o       - one-cycle pulse when a byte is dropped on a full FIFO
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned FREQ_HZ    = 12000000,
  parameter int unsigned BAUDS      = 115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       framing_error_o,
  output logic       overrun_o
);

  localparam int unsigned DIV   = baud_div(FREQ_HZ, BAUDS);
  localparam int unsigned CNT_W = $clog2(DIV);

  // The counter counts down to zero, so it is loaded with the interval minus
  // one; this keeps the reload values inside CNT_W bits even when DIV is a
  // power of two.
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(DIV / 2 - 1);

  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 sync1_q, sync2_q, rx_prev_q;
  logic                 framing_q, framing_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_s;
  logic                 rx_fall;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;

  // NOTE: the synchronizer resets to the idle level (1) so leaving reset on an
  // idle line never looks like a start bit.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  assign rx_s    = sync2_q;
  assign rx_fall = rx_prev_q && !rx_s;

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      framing_q <= framing_d;
      overrun_q <= overrun_d;
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push      = 1'b0;
    framing_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          cnt_d   = HALF_RELOAD;
          state_d = START;
        end
      end

      // Half a bit after the edge: confirm the start bit is still low.
      START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            cnt_d     = BIT_RELOAD;
            bit_cnt_d = '0;
            state_d   = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = BIT_RELOAD;
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            framing_d = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // A low stop bit means the line may still be in a break; wait for it to
      // return high so the next start edge is a genuine one.
      WAIT_IDLE: begin
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign pop       = valid_o && ready_i;
  assign overrun_d = push && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n_i),
    .push_i  (push),
    .data_i  (shift_q),
    .full_o  (fifo_full),
    .pop_i   (pop),
    .data_o  (data_o),
    .empty_o (fifo_empty)
  );

  assign valid_o         = !fifo_empty;
  assign framing_error_o = framing_q;
  assign overrun_o       = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. The line is driven bit by bit from the
// clock; a monitor records every accepted byte and every error pulse, and the
// expected byte stream / pulse counts come from the 8N1 + bounded-FIFO rules.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned FREQ_HZ    = 12_000_000;
  localparam int unsigned BAUDS      = 115_200;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DIV        = FREQ_HZ / BAUDS;
  // Edges from driving the start bit low to the receiver's stop-bit sample:
  // two synchronizer flops plus edge detect, half a bit, then nine full bits.
  localparam int unsigned STOP_SAMPLE = 3 + DIV / 2 + 9 * DIV;

  logic       clk;
  logic       reset_n_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       framing_error_o;
  logic       overrun_o;

  uart_rx #(
    .FREQ_HZ    (FREQ_HZ),
    .BAUDS      (BAUDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk             (clk),
    .reset_n_i       (reset_n_i),
    .rx_i            (rx_i),
    .data_o          (data_o),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .framing_error_o (framing_error_o),
    .overrun_o       (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Monitor: the only writer of these, sampling on the falling edge.
  int unsigned valid_cycles = 0;
  int unsigned fe_pulses    = 0;
  int unsigned ov_pulses    = 0;
  logic [7:0]  got_q[$];

  always @(negedge clk) begin
    if (reset_n_i) begin
      if (valid_o) begin
        valid_cycles++;
        if (ready_i) got_q.push_back(data_o);
      end
      if (framing_error_o) fe_pulses++;
      if (overrun_o)       ov_pulses++;
    end
  end

  // Snapshot of the monitor at the start of each scenario.
  int unsigned base_valid, base_fe, base_ov, base_got;
  logic [7:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic mark();
    base_valid = valid_cycles;
    base_fe    = fe_pulses;
    base_ov    = ov_pulses;
    base_got   = got_q.size();
  endtask

  // Compare bytes received since mark() with exp_q, then clear exp_q.
  task automatic check_rx(input string tag);
    logic [31:0] act;
    check({tag, "_count"}, got_q.size() - base_got, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      act = (base_got + i < got_q.size()) ? {24'd0, got_q[base_got + i]} : 32'hDEAD;
      check($sformatf("%s[%0d]", tag, i), act, {24'd0, exp_q[i]});
    end
    exp_q.delete();
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One 8N1 frame, LSB first; the line is left idle-high afterwards.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      tick(DIV);
    end
    rx_i = stop_bit;
    tick(DIV);
    rx_i = 1'b1;
  endtask

  logic [7:0] b;
  logic [7:0] fill_q[$];
  bit         rnd_done;
  int unsigned n_bad;

  initial begin
    reset_n_i = 1'b0;
    rx_i      = 1'b1;
    ready_i   = 1'b0;
    tick(5);
    check("reset_valid", valid_o, 0);
    check("reset_fe", framing_error_o, 0);
    check("reset_ov", overrun_o, 0);
    reset_n_i = 1'b1;
    tick(DIV);

    // Single byte, consumer always ready.
    ready_i = 1'b1;
    mark();
    send_byte(8'hA5, 1'b1);
    tick(20);
    check("a5_valid_cycles", valid_cycles - base_valid, 1);
    check("a5_fe", fe_pulses - base_fe, 0);
    check("a5_ov", ov_pulses - base_ov, 0);
    exp_q.push_back(8'hA5);
    check_rx("a5");

    // Short low glitch is a false start; the receiver must still take a frame.
    mark();
    rx_i = 1'b0;
    tick(20);
    rx_i = 1'b1;
    tick(2 * DIV);
    check("glitch_valid", valid_cycles - base_valid, 0);
    check("glitch_fe", fe_pulses - base_fe, 0);
    check_rx("glitch");
    b = 8'($urandom);
    send_byte(b, 1'b1);
    tick(20);
    exp_q.push_back(b);
    check_rx("after_glitch");

    // Bad stop bit, then a good frame.
    mark();
    send_byte(8'h3C, 1'b0);
    tick(DIV);
    check("framing_fe", fe_pulses - base_fe, 1);
    check("framing_valid", valid_cycles - base_valid, 0);
    check_rx("framing");
    mark();
    send_byte(8'h55, 1'b1);
    tick(20);
    check("after_framing_fe", fe_pulses - base_fe, 0);
    exp_q.push_back(8'h55);
    check_rx("after_framing");

    // Overrun: five bytes into a four-entry FIFO with nobody reading.
    ready_i = 1'b0;
    mark();
    for (int k = 1; k <= 4; k++) begin
      send_byte(8'(k), 1'b1);
      tick(4);
    end
    check("ov_before_5", ov_pulses - base_ov, 0);
    send_byte(8'h05, 1'b1);
    tick(4);
    check("ov_on_5", ov_pulses - base_ov, 1);
    ready_i = 1'b1;
    tick(10);
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    check_rx("overrun_drain");
    check("ov_total", ov_pulses - base_ov, 1);

    // Reset during bit 4 of a frame whose remaining bits are all 1, so no
    // falling edge appears until the next real start bit.
    mark();
    b = {4'hF, 4'($urandom)};
    rx_i = 1'b0;
    tick(DIV);
    for (int i = 0; i < 4; i++) begin
      rx_i = b[i];
      tick(DIV);
    end
    rx_i = 1'b1;
    tick(DIV / 2);
    reset_n_i = 1'b0;
    tick(3);
    check("midreset_valid", valid_o, 0);
    check("midreset_fe", framing_error_o, 0);
    reset_n_i = 1'b1;
    tick(DIV / 2 + 4 * DIV);
    send_byte(8'h7E, 1'b1);
    tick(20);
    check("midreset_fe_after", fe_pulses - base_fe, 0);
    exp_q.push_back(8'h7E);
    check_rx("midreset");

    // Full FIFO with a pop in exactly the cycle the fifth byte is pushed.
    ready_i = 1'b0;
    mark();
    fill_q.delete();
    for (int k = 0; k < 5; k++) fill_q.push_back(8'($urandom));
    for (int k = 0; k < 4; k++) begin
      send_byte(fill_q[k], 1'b1);
      tick(4);
    end
    check("full_valid", valid_o, 1);
    fork
      send_byte(fill_q[4], 1'b1);
      begin
        tick(STOP_SAMPLE - 1);
        ready_i = 1'b1;
        tick(1);
        ready_i = 1'b0;
      end
    join
    tick(4);
    check("fullpop_ov", ov_pulses - base_ov, 0);
    ready_i = 1'b1;
    tick(10);
    for (int k = 0; k < 5; k++) exp_q.push_back(fill_q[k]);
    check_rx("fullpop");

    // Random bytes, random consumer stalls, occasional bad stop bits.
    mark();
    n_bad    = 0;
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          logic bad;
          b   = 8'($urandom);
          bad = ($urandom_range(0, 4) == 0);
          send_byte(b, !bad);
          if (bad) n_bad++;
          else     exp_q.push_back(b);
          tick($urandom_range(6, 30));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          ready_i = 1'($urandom_range(0, 1));
          tick(1);
        end
      end
    join
    ready_i = 1'b1;
    tick(20);
    check("random_fe", fe_pulses - base_fe, n_bad);
    check("random_ov", ov_pulses - base_ov, 0);
    check_rx("random");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
